// File: rtl/mod_inv.sv
// mod_inv: sequential modular inverter over Z_q (Kyber, q = 3329).
// Computes res = a^(Q-2) mod Q using MSB-first square-and-multiply on
// one 3-stage multiply-and-reduce datapath. For a != 0 this is a^-1 mod Q.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  request pulse, accepted only in IDLE
//   a      12-bit operand captured on accept (reduced once if a >= Q)
//   res    12-bit result, held from done until the next accepted start
//   busy   high from accept through the done cycle
//   done   one-cycle pulse, res valid
//
// state | meaning
// IDLE  | waiting for start
// SQ    | acc <= acc*acc mod Q (MUL_LAT cycles)
// MUL   | acc <= acc*base mod Q (MUL_LAT cycles)
// DONE  | publish acc to res, pulse done
module mod_inv #(
    parameter int unsigned Q       = 3329,
    parameter logic [11:0] EXP     = 12'd3327,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] a,
    output logic [11:0] res,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, SQ, MUL, DONE} state_t;

    // Barrett constant floor(2^24 / Q); with a 24-bit product the estimated
    // quotient is at most one short, so a single conditional subtract is exact.
    localparam int unsigned BAR_M    = (1 << 24) / Q;
    localparam logic [1:0]  CNT_LAST = 2'(MUL_LAT - 1);

    state_t      state;
    logic [1:0]  cnt;
    logic [3:0]  idx;
    logic [11:0] base;
    logic [11:0] acc;
    logic [11:0] op_a;
    logic [11:0] op_b;
    logic [23:0] prod;

    logic [11:0] a_red;
    logic [12:0] qhat;
    logic [12:0] rem;
    logic [11:0] red;

    always_comb begin
        a_red = (a >= 12'(Q)) ? (a - 12'(Q)) : a;
        qhat  = 13'(({13'd0, prod} * 37'(BAR_M)) >> 24);
        // true remainder is < 2Q < 2^13, so modulo-2^13 arithmetic is exact
        rem   = 13'(25'(prod) - 25'(qhat) * 25'(Q));
        red   = (rem >= 13'(Q)) ? 12'(rem - 13'(Q)) : rem[11:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
            idx   <= 4'd0;
            base  <= 12'd0;
            acc   <= 12'd0;
            op_a  <= 12'd0;
            op_b  <= 12'd0;
            prod  <= 24'd0;
            res   <= 12'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // EXP MSB is 1, so the first step is acc = base
                        base  <= a_red;
                        acc   <= a_red;
                        idx   <= 4'd10;
                        cnt   <= 2'd0;
                        busy  <= 1'b1;
                        state <= SQ;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SQ, MUL: begin
                    if (cnt == 2'd0) begin
                        op_a <= acc;
                        op_b <= (state == MUL) ? base : acc;
                        cnt  <= 2'd1;
                    end else if (cnt != CNT_LAST) begin
                        prod <= {12'd0, op_a} * {12'd0, op_b};
                        cnt  <= cnt + 2'd1;
                    end else begin
                        // acc doubles as the reduced-result register
                        acc <= red;
                        cnt <= 2'd0;
                        if (state == SQ && EXP[idx]) begin
                            state <= MUL;
                        end else if (idx == 4'd0) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx - 4'd1;
                            state <= SQ;
                        end
                    end
                end
                DONE: begin
                    res   <= acc;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_red_lt_q: assert property (@(posedge clk) disable iff (rst)
        ((state == SQ || state == MUL) && cnt == CNT_LAST) |-> (red < 12'(Q)));

endmodule

// File: tb/tb_mod_inv.sv
module tb_mod_inv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] a = 12'd0;
    logic [11:0] res;
    logic        busy;
    logic        done;

    mod_inv dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .res   (res),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int a_eff;
        int res;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int accepts = 0;
    int dones = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (time %0t)", name, act, req, $time);
        end
    endtask

    function automatic int modpow(input int b);
        logic [11:0] e;
        int r;
        e = 12'd3327;
        r = 1;
        for (int i = 11; i >= 0; i--) begin
            r = (r * r) % 3329;
            if (e[i]) r = (r * b) % 3329;
        end
        return r;
    endfunction

    // monitor: every done pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && done) begin
            dones++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res", int'(res), e.res);
                chk("done_cycle", cyc, e.cyc);
                if (e.a_eff != 0) chk("inverse", (e.a_eff * int'(res)) % 3329, 1);
            end
        end
    end

    // called shortly after a negedge; start is sampled at the next posedge
    task automatic issue(input logic [11:0] av, input int r, input int a_eff, output int acc_cyc);
        acc_cyc = cyc + 1;
        start = 1'b1;
        a = av;
        sb.push_back('{a_eff, r, acc_cyc + 61});
        accepts++;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [11:0] av;
        int r;
        int a_eff;
    } vec_t;

    initial begin
        vec_t vecs[$];
        int e;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_res", int'(res), 0);
        rst = 1'b0;
        @(negedge clk);
        #1;

        // a=2: busy window and exact done cycle
        issue(12'd2, 1665, 2, e);
        for (int k = 1; k <= 62; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("busy_c%0d", k), int'(busy), (k <= 61) ? 1 : 0);
            if (k >= 60) chk($sformatf("done_c%0d", k), int'(done), (k == 61) ? 1 : 0);
        end
        drain();

        vecs.push_back('{12'd3, 1110, 3});
        vecs.push_back('{12'd17, 1175, 17});
        vecs.push_back('{12'd3328, 3328, 3328});
        vecs.push_back('{12'd0, 0, 0});
        vecs.push_back('{12'd1, 1, 1});
        vecs.push_back('{12'd3330, 1, 1});
        foreach (vecs[i]) begin
            issue(vecs[i].av, vecs[i].r, vecs[i].a_eff, e);
            drain();
        end

        // start while busy and in the DONE cycle is ignored; next cycle accepted
        issue(12'd2, 1665, 2, e);
        wait_cyc(e + 29);
        start = 1'b1;
        a = 12'd5;
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_cyc(e + 60);
        start = 1'b1;
        a = 12'd7;
        @(negedge clk);
        #1;
        chk("cycle_before_reaccept", cyc, e + 61);
        a = 12'd3;
        sb.push_back('{3, 1110, e + 62 + 61});
        accepts++;
        @(negedge clk);
        #1;
        start = 1'b0;
        drain();

        // asynchronous reset mid-computation
        issue(12'd17, 1175, 17, e);
        wait_cyc(e + 40);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_res", int'(res), 0);
        sb.delete();
        accepts--;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (80) @(negedge clk);
        #1;
        issue(12'd17, 1175, 17, e);
        drain();

        // sampled sweep against a reference exponentiation
        for (int v = 1; v < 3329; v += 83) begin
            issue(12'(v), modpow(v), v, e);
            drain();
        end
        issue(12'd3328, modpow(3328), 3328, e);
        drain();

        chk("done_count", dones, accepts);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
